// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-ported memory target that sits behind a valid/ready request channel
// and a valid/ready response channel. It takes one request at a time. Each
// request passes through a programmable number of wait states, is committed
// to the internal register-array memory in one ACCESS cycle, and is then
// presented as a response. The response is held until the initiator takes it.
//
// Parameters
//   DATA_W      : data word width (default 8)
//   ADDR_W      : word address width, memory depth is 2**ADDR_W (default 4)
//   WAIT_CYCLES : wait states between accept and access, legal range 0..15
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   initiator presents a request
//   req_write  in   1 = store, 0 = load
//   req_addr   in   word address
//   req_wdata  in   store data
//   req_ready  out  responder can accept a request (IDLE only)
//   rsp_valid  out  response available (RESP only)
//   rsp_rdata  out  load data, or the stored word for a store
//   rsp_write  out  req_write of the request this response belongs to
//   rsp_ready  in   initiator accepts the response
//   busy       out  high in every state other than IDLE
//
// Timing
//   accept edge -> WAIT_CYCLES edges in WAIT -> one edge in ACCESS -> RESP,
//   so rsp_valid becomes visible WAIT_CYCLES+1 edges after the accept edge.
//   With WAIT_CYCLES=0 the accept edge goes straight to ACCESS.
//   After the response handshake edge the block is back in IDLE, so the
//   tightest request spacing is WAIT_CYCLES+3 cycles.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    input  logic              rsp_ready,

    output logic              busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int DEPTH = 1 << ADDR_W;

    // The wait counter only ever needs to hold 0..15.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // FSM encoding kept as plain constants so the netlist state values stay
    // stable across tool versions.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Request captured at the accept edge; the live request inputs are never
    // looked at again until the block is back in IDLE.
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              write_q,  write_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    // Response registers, loaded only on the ACCESS->RESP edge so they hold
    // their last value through IDLE/WAIT/ACCESS.
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              rwrite_q, rwrite_d;

    // Register-array memory.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              mem_we;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // req_ready is a pure function of the state register so it drops the
    // moment the block leaves IDLE; req_valid in any other state is ignored.
    assign accept = (state_q == ST_IDLE) && req_valid;

    // The store commits on the ACCESS->RESP edge using the latched request.
    assign mem_we = (state_q == ST_ACCESS) && write_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rwrite_d = rwrite_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end

            ST_WAIT: begin
                // The counter counts down the remaining wait edges; the edge
                // seen with a count of one is the last wait edge. A count of
                // zero cannot occur here but is treated the same way so the
                // FSM can never stall in WAIT.
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // A store echoes the written word; a load reads the array.
                // The store itself lands in the array on this same edge, so a
                // following load to the same address always sees it.
                state_d  = ST_RESP;
                rwrite_d = write_q;
                rdata_d  = write_q ? wdata_q : mem_q[addr_q];
            end

            ST_RESP: begin
                // rsp_ready is only acted on here; elsewhere it is ignored.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rwrite_q <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rwrite_q <= rwrite_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately built from resettable flops so that a
    // reset wipes every word, including a store committed just before it;
    // this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // All status outputs decode the state register directly, so an
    // asynchronous reset takes them to their idle values immediately.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_write = rwrite_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Two instances share one clock and reset: dut_a with WAIT_CYCLES=2 and
// dut_b with WAIT_CYCLES=0. Expected responses are pushed to a scoreboard
// queue when a request is accepted and popped when the response appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    // dut_a : WAIT_CYCLES = 2
    logic       a_req_valid, a_req_write, a_req_ready;
    logic [3:0] a_req_addr;
    logic [7:0] a_req_wdata, a_rsp_rdata;
    logic       a_rsp_valid, a_rsp_write, a_rsp_ready, a_busy;

    // dut_b : WAIT_CYCLES = 0
    logic       b_req_valid, b_req_write, b_req_ready;
    logic [3:0] b_req_addr;
    logic [7:0] b_req_wdata, b_rsp_rdata;
    logic       b_rsp_valid, b_rsp_write, b_rsp_ready, b_busy;

    mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (a_req_valid),
        .req_write (a_req_write),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .req_ready (a_req_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_rdata (a_rsp_rdata),
        .rsp_write (a_rsp_write),
        .rsp_ready (a_rsp_ready),
        .busy      (a_busy)
    );

    mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (b_req_valid),
        .req_write (b_req_write),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .req_ready (b_req_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_rdata (b_rsp_rdata),
        .rsp_write (b_rsp_write),
        .rsp_ready (b_rsp_ready),
        .busy      (b_busy)
    );

    typedef struct packed {
        logic       write;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------------------------------------------------------- access
    task automatic set_req(input bit z, input logic v, input logic w,
                           input logic [3:0] a, input logic [7:0] d);
        if (z) begin
            b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = d;
        end
    endtask

    task automatic set_rsp_ready(input bit z, input logic r);
        if (z) b_rsp_ready = r;
        else   a_rsp_ready = r;
    endtask

    function automatic logic get_ready(input bit z);
        return z ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic get_rv(input bit z);
        return z ? b_rsp_valid : a_rsp_valid;
    endfunction

    function automatic logic [7:0] get_rdata(input bit z);
        return z ? b_rsp_rdata : a_rsp_rdata;
    endfunction

    function automatic logic get_rwrite(input bit z);
        return z ? b_rsp_write : a_rsp_write;
    endfunction

    function automatic logic get_busy(input bit z);
        return z ? b_busy : a_busy;
    endfunction

    // One complete request/response exchange on the selected instance.
    // hold     : cycles of rsp_ready=0 while the response is presented
    // scramble : randomise addr/wdata (valid held high) until the response
    task automatic transact(input bit z, input logic w, input logic [3:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_data,
                            input int exp_lat, input int hold,
                            input bit scramble, input string name);
        int         lat;
        int         guard;
        exp_t       e;
        logic [7:0] held;

        @(negedge clk);
        set_req(z, 1'b1, w, addr, wdata);
        set_rsp_ready(z, 1'b0);
        guard = 0;
        while (!get_ready(z) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (get_ready(z) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b required=1", name, get_ready(z));
            set_req(z, 1'b0, w, addr, wdata);
            return;
        end
        sb_q.push_back('{write: w, data: exp_data});

        @(negedge clk);
        if (!scramble) set_req(z, 1'b0, w, addr, wdata);
        lat = 0;
        while (!get_rv(z) && lat < 20) begin
            n_checks++;
            if (get_ready(z) !== 1'b0 || get_busy(z) !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy: req_ready=%b busy=%b required 0/1",
                         name, get_ready(z), get_busy(z));
            end
            if (scramble) set_req(z, 1'b1, w, 4'($urandom_range(15)), 8'($urandom_range(255)));
            @(negedge clk);
            lat++;
        end
        set_req(z, 1'b0, w, addr, wdata);

        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: edges=%0d required=%0d", name, lat, exp_lat);
        end
        if (!get_rv(z)) begin
            void'(sb_q.pop_back());
            return;
        end

        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: unexpected response rdata=%h", name, get_rdata(z));
        end else begin
            e = sb_q.pop_front();
            if (get_rdata(z) !== e.data || get_rwrite(z) !== e.write) begin
                n_fail++;
                $display("FAIL %s response: rdata=%h write=%b required rdata=%h write=%b",
                         name, get_rdata(z), get_rwrite(z), e.data, e.write);
            end
        end

        held = get_rdata(z);
        repeat (hold) begin
            @(negedge clk);
            n_checks++;
            if (get_rv(z) !== 1'b1 || get_rdata(z) !== held || get_ready(z) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s backpressure: rsp_valid=%b rdata=%h req_ready=%b required 1/%h/0",
                         name, get_rv(z), get_rdata(z), get_ready(z), held);
            end
        end

        set_rsp_ready(z, 1'b1);
        @(negedge clk);
        set_rsp_ready(z, 1'b0);
        n_checks++;
        if (get_ready(z) !== 1'b1 || get_rv(z) !== 1'b0 || get_busy(z) !== 1'b0 ||
            get_rdata(z) !== held) begin
            n_fail++;
            $display("FAIL %s handshake: req_ready=%b rsp_valid=%b busy=%b rdata=%h required 1/0/0/%h",
                     name, get_ready(z), get_rv(z), get_busy(z), get_rdata(z), held);
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int z = 0; z < 2; z++) begin
            n_checks++;
            if (get_rv(z[0]) !== 1'b0 || get_rdata(z[0]) !== 8'h00 ||
                get_rwrite(z[0]) !== 1'b0 || get_busy(z[0]) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: rsp_valid=%b rdata=%h write=%b busy=%b required 0/00/0/0",
                         z, get_rv(z[0]), get_rdata(z[0]), get_rwrite(z[0]), get_busy(z[0]));
            end
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int z = 0; z < 2; z++) begin
            n_checks++;
            if (get_ready(z[0]) !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready dut%0d: req_ready=%b required=1", z, get_ready(z[0]));
            end
        end
    endtask

    task automatic test_store_load();
        transact(1'b0, 1'b1, 4'd3, 8'hA5, 8'hA5, 3, 0, 1'b0, "store3");
        transact(1'b0, 1'b0, 4'd3, 8'h5A, 8'hA5, 3, 0, 1'b0, "load3");
    endtask

    task automatic test_backpressure();
        transact(1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 3, 5, 1'b0, "bp_load3");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 4'd7, 8'hFF);
        n_checks++;
        if (a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_accept: req_ready=%b required=1", a_req_ready);
        end
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_wait: busy=%b required=1", a_busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 8'h00 || a_rsp_write !== 1'b0 ||
            a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_outputs: rsp_valid=%b rdata=%h write=%b busy=%b req_ready=%b required 0/00/0/0/1",
                     a_rsp_valid, a_rsp_rdata, a_rsp_write, a_busy, a_req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        transact(1'b0, 1'b0, 4'd7, 8'h00, 8'h00, 3, 0, 1'b0, "midrst_load7");
        transact(1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 3, 0, 1'b0, "midrst_load3_cleared");
    endtask

    task automatic test_isolation();
        transact(1'b0, 1'b1, 4'd2, 8'h11, 8'h11, 3, 0, 1'b1, "iso_store2");
        for (int i = 0; i < 16; i++) begin
            transact(1'b0, 1'b0, 4'(i), 8'h00, (i == 2) ? 8'h11 : 8'h00, 3, 0, 1'b0,
                     $sformatf("iso_load%0d", i));
        end
    endtask

    task automatic test_wrap();
        transact(1'b0, 1'b1, 4'd0,  8'h5C, 8'h5C, 3, 0, 1'b0, "wrap_store0");
        transact(1'b0, 1'b1, 4'd15, 8'hC3, 8'hC3, 3, 0, 1'b0, "wrap_store15");
        transact(1'b0, 1'b0, 4'd0,  8'h00, 8'h5C, 3, 0, 1'b0, "wrap_load0");
        transact(1'b0, 1'b0, 4'd15, 8'h00, 8'hC3, 3, 0, 1'b0, "wrap_load15");
    endtask

    task automatic test_zero_wait();
        transact(1'b1, 1'b1, 4'd15, 8'h3C, 8'h3C, 1, 0, 1'b0, "zw_store15");
        transact(1'b1, 1'b0, 4'd15, 8'h00, 8'h3C, 1, 0, 1'b0, "zw_load15");
    endtask

    task automatic test_back_to_back();
        int   acc_k[$];
        int   idx;
        bit   pending;
        exp_t e;

        @(negedge clk);
        idx     = 0;
        pending = 1'b0;
        set_req(1'b1, 1'b1, 1'b1, 4'd4, 8'h40);
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (pending) begin
                pending = 1'b0;
                if (idx < 4) set_req(1'b1, 1'b1, 1'b1, 4'(4 + idx), 8'(8'h40 + idx));
                else         set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
            end
            if (b_rsp_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_scoreboard: unexpected response rdata=%h", b_rsp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (b_rsp_rdata !== e.data || b_rsp_write !== e.write) begin
                        n_fail++;
                        $display("FAIL b2b_response: rdata=%h write=%b required rdata=%h write=%b",
                                 b_rsp_rdata, b_rsp_write, e.data, e.write);
                    end
                end
            end
            if (b_req_ready && b_req_valid) begin
                acc_k.push_back(k);
                sb_q.push_back('{write: 1'b1, data: b_req_wdata});
                idx++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        b_rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);

        n_checks++;
        if (acc_k.size() != 4 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d pending_rsp=%0d required 4/0",
                     acc_k.size(), sb_q.size());
        end
        for (int i = 1; i < acc_k.size(); i++) begin
            n_checks++;
            if (acc_k[i] - acc_k[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: cycles=%0d required=3", i, acc_k[i] - acc_k[i-1]);
            end
        end
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin
            transact(1'b1, 1'b0, 4'(4 + i), 8'h00, 8'(8'h40 + i), 1, 0, 1'b0,
                     $sformatf("b2b_load%0d", 4 + i));
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_mid_reset();
        test_isolation();
        test_wrap();
        test_zero_wait();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
